dsp_mac_sequencer: RTL and testbench

- Upstream controller for one DSP48A1 slice. Turns a valid/ready stream of (A,B) operand pairs, grouped into vectors by a last flag, into A/B/OPMODE/CEP drive so the slice computes unsigned dot products sum(A*B) in P.
- Captures P when the final term of each vector retires and presents it on a one-deep valid/ready result port.
- Timing is fixed for the slice configured as A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, OPMODEREG=1, PREG=1, B_INPUT="DIRECT", with CEA/CEB/CEM tied high and CEOPMODE tied high.

---
 rtl/dsp_mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Operand sequencer for one DSP48A1 slice: streams (A,B) pairs into the slice,
// schedules OPMODE/CEP against the slice pipeline and returns each dot product.
module dsp_mac_sequencer #(
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9,
  parameter int SUB       = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_last,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cep,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             err_len
);

  // X=M with Z=0 starts a sum, X=M with Z=P extends it; bit 7 selects subtract.
  localparam logic [7:0] OPM_FIRST = (SUB != 0) ? 8'h81 : 8'h01;
  localparam logic [7:0] OPM_ACC   = (SUB != 0) ? 8'h89 : 8'h09;

  // Tag bits: [2] valid, [1] first, [0] last. Index k-1 holds the tag at point e+k.
  logic [3:0][2:0]  tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pend_cnt_q, pend_cnt_d, cnt_inc_s;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic [47:0]      res_data_q, res_data_d;
  logic [17:0]      dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
  logic [7:0]       dsp_opmode_q, dsp_opmode_d;
  logic             dsp_cep_q, dsp_cep_d;
  logic             busy_q, busy_d, err_q, err_d, res_valid_q, res_valid_d;
  logic             accept_s, hit_max_s, last_s;

  assign accept_s  = in_valid && !busy_q;
  assign cnt_inc_s = cnt_q + CNT_W'(1);
  assign hit_max_s = (cnt_inc_s == CNT_W'(MAX_TERMS));
  assign last_s    = in_last || hit_max_s;

  always_comb begin
    cnt_d        = cnt_q;
    pend_cnt_d   = pend_cnt_q;
    dsp_a_d      = dsp_a_q;
    dsp_b_d      = dsp_b_q;
    dsp_opmode_d = dsp_opmode_q;
    busy_d       = busy_q;
    err_d        = err_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_count_d  = res_count_q;
    tag_d        = {tag_q[2:0], 3'b000};

    if (accept_s) begin
      dsp_a_d  = in_a;
      dsp_b_d  = in_b;
      tag_d[0] = {1'b1, (cnt_q == CNT_W'(0)), last_s};
      if (last_s) begin
        cnt_d      = CNT_W'(0);
        pend_cnt_d = cnt_inc_s;
        busy_d     = 1'b1;
      end else begin
        cnt_d = cnt_inc_s;
      end
      if (hit_max_s && !in_last) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      tag_d[0] = 3'b000;
    end

    // OPMODE must sit in the slice's OPMODE register while M holds the product.
    if (tag_q[0][2]) begin
      dsp_opmode_d = tag_q[0][1] ? OPM_FIRST : OPM_ACC;
    end else begin
      dsp_opmode_d = dsp_opmode_q;
    end
    dsp_cep_d = tag_q[1][2];

    // A new vector cannot start before the handoff, so capture and handoff never collide.
    if (tag_q[3][2] && tag_q[3][0]) begin
      res_valid_d = 1'b1;
      res_data_d  = dsp_p;
      res_count_d = pend_cnt_q;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_q        <= '0;
      cnt_q        <= '0;
      pend_cnt_q   <= '0;
      dsp_a_q      <= 18'd0;
      dsp_b_q      <= 18'd0;
      dsp_opmode_q <= 8'd0;
      dsp_cep_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 48'd0;
      res_count_q  <= '0;
    end else begin
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      pend_cnt_q   <= pend_cnt_d;
      dsp_a_q      <= dsp_a_d;
      dsp_b_q      <= dsp_b_d;
      dsp_opmode_q <= dsp_opmode_d;
      dsp_cep_q    <= dsp_cep_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_count_q  <= res_count_d;
    end
  end

  assign in_ready   = !busy_q;
  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_opmode = dsp_opmode_q;
  assign dsp_cep    = dsp_cep_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_count  = res_count_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench: three sequencers (default, MAX_TERMS=4, SUB=1), each driving
// a behavioural DSP48A1 slice (A1/B1/M/OPMODE/P registers, CEP-gated P).
module tb_dsp_mac_sequencer;

  logic        clk, rst;
  logic        in_valid [3];
  logic        in_ready [3];
  logic        in_last  [3];
  logic [17:0] in_a     [3];
  logic [17:0] in_b     [3];
  logic [17:0] dsp_a    [3];
  logic [17:0] dsp_b    [3];
  logic [7:0]  dsp_opmode [3];
  logic        dsp_cep  [3];
  logic        res_valid [3];
  logic        res_ready [3];
  logic [47:0] res_data [3];
  logic [8:0]  res_count [3];
  logic        err_len  [3];

  int n_assert = 0;
  int n_fail   = 0;
  int cep_cnt  = 0;
  logic [47:0] cap_data [$];
  logic [8:0]  cap_cnt  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    logic [17:0] a1, b1;
    logic [35:0] m;
    logic [7:0]  opm;
    logic [47:0] p, z, x;

    dsp_mac_sequencer #(.MAX_TERMS(g == 1 ? 4 : 256), .CNT_W(9), .SUB(g == 2 ? 1 : 0)) dut (
      .CLK(clk), .RST(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .in_last(in_last[g]),
      .dsp_a(dsp_a[g]), .dsp_b(dsp_b[g]), .dsp_opmode(dsp_opmode[g]), .dsp_cep(dsp_cep[g]),
      .dsp_p(p),
      .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .res_data(res_data[g]), .res_count(res_count[g]), .err_len(err_len[g])
    );

    always_comb begin
      z = (opm[3:2] == 2'b10) ? p : 48'd0;
      x = (opm[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
    end

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        a1 <= 18'd0; b1 <= 18'd0; m <= 36'd0; opm <= 8'd0; p <= 48'd0;
      end else begin
        a1  <= dsp_a[g];
        b1  <= dsp_b[g];
        m   <= a1 * b1;
        opm <= dsp_opmode[g];
        if (dsp_cep[g]) p <= opm[7] ? (z - x) : (z + x);
      end
    end
  end

  always @(negedge clk) begin
    if (dsp_cep[0]) cep_cnt++;
    if (res_valid[1] && res_ready[1]) begin
      cap_data.push_back(res_data[1]);
      cap_cnt.push_back(res_count[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [17:0] a, input logic [17:0] b, input logic last);
    int w = 0;
    in_a[k] = a; in_b[k] = b; in_last[k] = last; in_valid[k] = 1'b1;
    while (!in_ready[k] && w < 100) begin
      tick();
      w++;
    end
    chk("send_timeout", 64'(w < 100), 64'd1);
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_res(input int k, output int lat);
    lat = 0;
    while (!res_valid[k] && lat < 30) begin
      tick();
      lat++;
    end
    chk("res_timeout", 64'(res_valid[k]), 64'd1);
  endtask

  initial begin
    int lat;
    int c0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_last[i] = 1'b0; in_a[i] = 18'd0; in_b[i] = 18'd0;
      res_ready[i] = 1'b1;
    end
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("rst_res_valid", 64'(res_valid[0]), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode[0]), 64'd0);
    chk("rst_cep", 64'(dsp_cep[0]), 64'd0);
    chk("rst_err", 64'(err_len[0]), 64'd0);
    chk("rst_res_data", 64'(res_data[0]), 64'd0);
    rst = 1'b0;
    tick();

    // Three-term vector: 3*4 + 5*6 + 7*8 = 98
    send(0, 18'd3, 18'd4, 1'b0);
    send(0, 18'd5, 18'd6, 1'b0);
    chk("v1_opm_first", 64'(dsp_opmode[0]), 64'h01);
    send(0, 18'd7, 18'd8, 1'b1);
    chk("v1_opm_acc2", 64'(dsp_opmode[0]), 64'h09);
    chk("v1_cep", 64'(dsp_cep[0]), 64'd1);
    chk("v1_ready_low", 64'(in_ready[0]), 64'd0);
    wait_res(0, lat);
    chk("v1_latency", 64'(lat), 64'd4);
    chk("v1_opm_acc3", 64'(dsp_opmode[0]), 64'h09);
    chk("v1_data", 64'(res_data[0]), 64'd98);
    chk("v1_count", 64'(res_count[0]), 64'd3);
    tick();
    chk("v1_handoff_valid", 64'(res_valid[0]), 64'd0);
    chk("v1_handoff_ready", 64'(in_ready[0]), 64'd1);

    // Single full-scale term
    send(0, 18'h3FFFF, 18'h3FFFF, 1'b1);
    tick();
    chk("v2_opm", 64'(dsp_opmode[0]), 64'h01);
    wait_res(0, lat);
    chk("v2_data", 64'(res_data[0]), 64'hF_FFF8_0001);
    chk("v2_count", 64'(res_count[0]), 64'd1);
    tick();

    // Bubbles inside a vector: 2*2 + 3*3 = 13, two CEP pulses
    c0 = cep_cnt;
    send(0, 18'd2, 18'd2, 1'b0);
    tick(); tick(); tick();
    chk("v3_opm_hold", 64'(dsp_opmode[0]), 64'h01);
    send(0, 18'd3, 18'd3, 1'b1);
    wait_res(0, lat);
    chk("v3_data", 64'(res_data[0]), 64'd13);
    chk("v3_cep_pulses", 64'(cep_cnt - c0), 64'd2);
    tick();

    // Back-pressure: result 7 held, new pair 9*9 waits for the handoff
    res_ready[0] = 1'b0;
    send(0, 18'd7, 18'd1, 1'b1);
    wait_res(0, lat);
    in_a[0] = 18'd9; in_b[0] = 18'd9; in_last[0] = 1'b1; in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ready_low", 64'(in_ready[0]), 64'd0);
    end
    chk("bp_valid", 64'(res_valid[0]), 64'd1);
    chk("bp_data", 64'(res_data[0]), 64'd7);
    chk("bp_count", 64'(res_count[0]), 64'd1);
    res_ready[0] = 1'b1;
    tick();
    chk("bp_handoff_valid", 64'(res_valid[0]), 64'd0);
    chk("bp_handoff_ready", 64'(in_ready[0]), 64'd1);
    tick();
    in_valid[0] = 1'b0;
    wait_res(0, lat);
    chk("bp_next_latency", 64'(lat), 64'd4);
    chk("bp_next_data", 64'(res_data[0]), 64'd81);
    tick();

    // Length limit on the MAX_TERMS=4 unit
    for (int i = 0; i < 3; i++) send(1, 18'd1, 18'd1, 1'b0);
    chk("len_err_before", 64'(err_len[1]), 64'd0);
    send(1, 18'd1, 18'd1, 1'b0);
    chk("len_err_set", 64'(err_len[1]), 64'd1);
    chk("len_ready_low", 64'(in_ready[1]), 64'd0);
    send(1, 18'd1, 18'd1, 1'b0);
    send(1, 18'd1, 18'd1, 1'b0);
    send(1, 18'd0, 18'd0, 1'b1);
    for (int i = 0; i < 40 && cap_data.size() < 2; i++) tick();
    chk("len_results", 64'(cap_data.size()), 64'd2);
    if (cap_data.size() >= 2) begin
      chk("len_r1_data", 64'(cap_data[0]), 64'd4);
      chk("len_r1_count", 64'(cap_cnt[0]), 64'd4);
      chk("len_r2_data", 64'(cap_data[1]), 64'd2);
      chk("len_r2_count", 64'(cap_cnt[1]), 64'd3);
    end
    chk("len_err_sticky", 64'(err_len[1]), 64'd1);

    // Subtracting unit: -(1*5 + 1*3)
    send(2, 18'd1, 18'd5, 1'b0);
    send(2, 18'd1, 18'd3, 1'b1);
    chk("sub_opm_first", 64'(dsp_opmode[2]), 64'h81);
    tick();
    chk("sub_opm_acc", 64'(dsp_opmode[2]), 64'h89);
    wait_res(2, lat);
    chk("sub_data", 64'(res_data[2]), 64'hFFFF_FFFF_FFF8);
    chk("sub_count", 64'(res_count[2]), 64'd2);

    // Reset in the middle of a vector; the result above is still held
    send(2, 18'd2, 18'd2, 1'b0);
    send(2, 18'd3, 18'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dsp_a", 64'(dsp_a[2]), 64'd0);
    chk("mid_rst_dsp_b", 64'(dsp_b[2]), 64'd0);
    chk("mid_rst_opm", 64'(dsp_opmode[2]), 64'd0);
    chk("mid_rst_cep", 64'(dsp_cep[2]), 64'd0);
    chk("mid_rst_valid", 64'(res_valid[2]), 64'd0);
    chk("mid_rst_data", 64'(res_data[2]), 64'd0);
    chk("mid_rst_count", 64'(res_count[2]), 64'd0);
    chk("mid_rst_err", 64'(err_len[1]), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(in_ready[2]), 64'd1);
    send(2, 18'd1, 18'd7, 1'b1);
    tick();
    chk("post_rst_opm", 64'(dsp_opmode[2]), 64'h81);
    wait_res(2, lat);
    chk("post_rst_data", 64'(res_data[2]), 64'hFFFF_FFFF_FFF9);
    chk("post_rst_count", 64'(res_count[2]), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
